// File: rtl/pixel_readout_capture.sv
// pixel_readout_capture
// Captures the column-parallel ADC result for each row at the falling edge of
// the ADC strobe, buffers one 2-row frame and streams it out pixel by pixel
// over a valid/ready interface. Same Clk domain as the exposure controller.
//
// Ports:
//   Clk, Reset      clock (rising edge), asynchronous active-high reset
//   NRE_1, NRE_2    row selects from the controller
//   ADC, Adc_data   conversion strobe and column results (column c at [c*DATA_W +: DATA_W])
//   Pix_ready       downstream ready
//   Pix_valid/Pix_data/Pix_last  pixel stream, Pix_last on row 2 column COLS-1
//   Frame_done      one-cycle pulse after the last pixel of a frame is accepted
//   Busy            capture in progress or buffer/output non-empty
//   Ovr             sticky: a capture hit a row that was still full
//   Seq_err         sticky protocol error (only with PROTOCOL_CHECK_EN defined)
//
// Build option PROTOCOL_CHECK_EN: flags both/neither row select on a capture
// and a row-2 capture with no row 1 pending; those captures are dropped.
// Without it Seq_err is 0, both-high counts as row 1 and bad captures are ignored.
//
// state   | meaning
// S_IDLE  | no frame open
// S_CAPT  | row 1 captured, row 2 pending
// S_DRAIN | both rows captured, streaming out
module pixel_readout_capture #(
   parameter int DATA_W = 8,
   parameter int COLS   = 2
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   NRE_1,
   input  logic                   NRE_2,
   input  logic                   ADC,
   input  logic [COLS*DATA_W-1:0] Adc_data,
   input  logic                   Pix_ready,
   output logic                   Pix_valid,
   output logic [DATA_W-1:0]      Pix_data,
   output logic                   Pix_last,
   output logic                   Frame_done,
   output logic                   Busy,
   output logic                   Ovr,
   output logic                   Seq_err
);

   localparam int NPIX = 2 * COLS;
   localparam int ROW_W = COLS * DATA_W;
   localparam int RD_W = $clog2(NPIX);
   localparam logic [RD_W-1:0] RD_LAST   = RD_W'(NPIX - 1);
   localparam logic [RD_W-1:0] ROW1_LAST = RD_W'(COLS - 1);
   localparam logic [RD_W-1:0] COLS_R    = RD_W'(COLS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CAPT  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic                   adc_q;
   logic [1:0]             full_q, full_d, full_drain;
   logic [RD_W-1:0]        rd_q, rd_d;
   logic                   valid_q, valid_d;
   logic [DATA_W-1:0]      data_q, data_d, nxt_pix;
   logic                   done_q;
   logic                   ovr_q, ovr_d;
   logic [NPIX*DATA_W-1:0] buf_q;
   logic                   hs, stall, row1_end, frame_end;
   logic                   cap_ev, sel1, sel2, row2_ok, wr1, wr2, ovr_hit;

   assign cap_ev = adc_q & ~ADC;

`ifdef PROTOCOL_CHECK_EN
   logic seq_err_q, seq_viol;

   assign sel1 = cap_ev & NRE_1 & ~NRE_2;
   assign sel2 = cap_ev & NRE_2 & ~NRE_1;
   assign seq_viol = cap_ev & (~(NRE_1 ^ NRE_2) | (sel2 & (state_q == S_IDLE)));

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) seq_err_q <= 1'b0;
      else       seq_err_q <= seq_err_q | seq_viol;
   end

   assign Seq_err = seq_err_q;
`else
   assign sel1 = cap_ev & NRE_1;
   assign sel2 = cap_ev & ~NRE_1 & NRE_2;
   assign Seq_err = 1'b0;
`endif

   always_comb begin
      hs        = valid_q & Pix_ready;
      stall     = valid_q & ~Pix_ready;
      row1_end  = hs & (rd_q == ROW1_LAST);
      frame_end = hs & (rd_q == RD_LAST);

      rd_d = rd_q;
      if (hs) rd_d = frame_end ? '0 : rd_q + RD_W'(1);

      // Drain is applied before capture so a row freed on this edge can be refilled.
      full_drain = full_q & ~{frame_end, row1_end};
      row2_ok    = sel2 & (state_q != S_IDLE);
      wr1        = sel1 & ~full_drain[0];
      wr2        = row2_ok & ~full_drain[1];
      ovr_hit    = (sel1 & full_drain[0]) | (row2_ok & full_drain[1]);
      full_d     = full_drain | {wr2, wr1};
      ovr_d      = ovr_q | ovr_hit;

      nxt_pix = '0;
      for (int i = 0; i < NPIX; i++) begin
         if (rd_d == RD_W'(i)) nxt_pix = buf_q[i*DATA_W +: DATA_W];
      end

      // Output register only reloads when not stalled; a row captured on this
      // edge becomes visible one edge later.
      valid_d = valid_q;
      data_d  = data_q;
      if (!stall) begin
         valid_d = full_drain[rd_d >= COLS_R];
         if (valid_d) data_d = nxt_pix;
      end
   end

   always_comb begin
      state_d = state_q;
      if (frame_end) begin
         if (full_d[0]) state_d = full_d[1] ? S_DRAIN : S_CAPT;
         else           state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (wr1) state_d = S_CAPT;
            S_CAPT:  if (wr2) state_d = S_DRAIN;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         adc_q   <= 1'b0;
         full_q  <= '0;
         rd_q    <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         adc_q   <= ADC;
         full_q  <= full_d;
         rd_q    <= rd_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         done_q  <= frame_end;
         ovr_q   <= ovr_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (wr1) buf_q[0 +: ROW_W]     <= Adc_data;
      if (wr2) buf_q[ROW_W +: ROW_W] <= Adc_data;
   end

   assign Pix_valid  = valid_q;
   assign Pix_data   = data_q;
   assign Pix_last   = valid_q & (rd_q == RD_LAST);
   assign Frame_done = done_q;
   assign Ovr        = ovr_q;
   assign Busy       = (state_q != S_IDLE) | (|full_q) | valid_q;

endmodule

// File: tb/tb_pixel_readout_capture.sv
module tb_pixel_readout_capture;

   localparam int DW = 8;
   localparam int C  = 2;
   localparam int NP = 2 * C;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic          NRE_1 = 1'b0, NRE_2 = 1'b0, ADC = 1'b0;
   logic [C*DW-1:0] Adc_data = '0;
   logic          Pix_ready = 1'b0;
   logic          Pix_valid, Pix_last, Frame_done, Busy, Ovr, Seq_err;
   logic [DW-1:0] Pix_data;

   pixel_readout_capture #(.DATA_W(DW), .COLS(C)) dut (
      .Clk(Clk), .Reset(Reset), .NRE_1(NRE_1), .NRE_2(NRE_2), .ADC(ADC),
      .Adc_data(Adc_data), .Pix_ready(Pix_ready), .Pix_valid(Pix_valid),
      .Pix_data(Pix_data), .Pix_last(Pix_last), .Frame_done(Frame_done),
      .Busy(Busy), .Ovr(Ovr), .Seq_err(Seq_err)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: two row slots, a stream position and a frame-open flag.
   bit            slot_occ [2];
   logic [DW-1:0] slot_pix [2][C];
   int            p = 0;
   bit            open_m = 0, m_valid = 0, m_ovr = 0, m_seq = 0, m_fd = 0, adc_prev = 0;
   bit            hs_m, fin_m, stall_m, o0, o1;
   int            row_m;
   logic [DW-1:0] acc_log[$];
   int            cyc = 0, cap1_cyc = -1, vrise_cyc = -1;
   bit            prev_valid = 0;
   int            rmode = 2;

   always @(negedge Clk) begin
      cyc++;
      if (Reset) begin
         chk("reset_outputs", 32'({Pix_valid, Pix_data, Pix_last, Frame_done, Busy, Ovr, Seq_err}), 32'd0);
         slot_occ[0] = 0; slot_occ[1] = 0;
         p = 0; open_m = 0; m_valid = 0; m_ovr = 0; m_seq = 0; m_fd = 0; adc_prev = 0;
         prev_valid = 0;
      end else begin
         chk("pix_valid", 32'(Pix_valid), 32'(m_valid));
         if (m_valid) begin
            chk("pix_data", 32'(Pix_data), 32'(slot_pix[p/C][p%C]));
            chk("pix_last", 32'(Pix_last), 32'(p == NP - 1));
         end else begin
            chk("pix_last_idle", 32'(Pix_last), 32'd0);
         end
         chk("frame_done", 32'(Frame_done), 32'(m_fd));
         chk("ovr", 32'(Ovr), 32'(m_ovr));
         chk("seq_err", 32'(Seq_err), 32'(m_seq));
         chk("busy", 32'(Busy), 32'(open_m | slot_occ[0] | slot_occ[1] | m_valid));
         if (Pix_valid && !prev_valid) vrise_cyc = cyc;
         prev_valid = Pix_valid;

         // Advance the model across the coming rising edge.
         stall_m = m_valid && !Pix_ready;
         hs_m    = m_valid && Pix_ready;
         fin_m   = hs_m && (p == NP - 1);
         if (hs_m) begin
            acc_log.push_back(Pix_data);
            if (p % C == C - 1) slot_occ[p/C] = 0;
            p = fin_m ? 0 : p + 1;
         end
         o0 = slot_occ[0];
         o1 = slot_occ[1];
         row_m = 0;
         if (adc_prev && !ADC) begin
`ifdef PROTOCOL_CHECK_EN
            if (NRE_1 == NRE_2) m_seq = 1;
            else if (NRE_1) row_m = 1;
            else if (!open_m) m_seq = 1;
            else row_m = 2;
`else
            if (NRE_1) row_m = 1;
            else if (NRE_2 && open_m) row_m = 2;
`endif
         end
         if (row_m != 0) begin
            if (slot_occ[row_m-1]) m_ovr = 1;
            else begin
               slot_occ[row_m-1] = 1;
               for (int c = 0; c < C; c++) slot_pix[row_m-1][c] = Adc_data[c*DW +: DW];
               if (row_m == 1) begin
                  open_m = 1;
                  cap1_cyc = cyc;
               end
            end
         end
         if (fin_m) open_m = slot_occ[0];
         m_valid = stall_m ? 1'b1 : ((p < C) ? o0 : o1);
         m_fd = fin_m;
         adc_prev = ADC;
      end
   end

   always @(posedge Clk) begin
      #1;
      case (rmode)
         0:       Pix_ready = 1'b1;
         1:       Pix_ready = ~Pix_ready;
         2:       Pix_ready = 1'b0;
         default: Pix_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   // r: 1 = row 1, 2 = row 2, 3 = both selects, 0 = neither
   task automatic capture_row(input int r, input logic [C*DW-1:0] d, input int hold);
      NRE_1 = (r == 1 || r == 3);
      NRE_2 = (r == 2 || r == 3);
      tick(1);
      ADC = 1'b1;
      Adc_data = d;
      tick(hold);
      ADC = 1'b0;
      tick(1);
      NRE_1 = 1'b0;
      NRE_2 = 1'b0;
      Adc_data = (C*DW)'($urandom);
   endtask

   task automatic frame(input logic [C*DW-1:0] d1, input logic [C*DW-1:0] d2, input int gap);
      capture_row(1, d1, $urandom_range(1, 3));
      tick(gap);
      capture_row(2, d2, $urandom_range(1, 3));
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (Busy && n < budget) begin
         tick(1);
         n++;
      end
      chk("drain_to_idle", 32'(Busy), 32'd0);
   endtask

   task automatic check_log(input string nm, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
      logic [7:0] e [4];
      e[0] = a; e[1] = b; e[2] = c; e[3] = d;
      chk({nm, "_len"}, 32'(acc_log.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < acc_log.size()) chk(nm, 32'(acc_log[i]), 32'(e[i]));
   endtask

   task automatic pulse_reset();
      Reset = 1'b1;
      tick(2);
      Reset = 1'b0;
      tick(1);
   endtask

   initial begin
      tick(3);
      Reset = 1'b0;
      tick(1);

      // Latency and nominal frame
      rmode = 2;
      acc_log.delete();
      capture_row(1, 16'hB2A1, 2);
      tick(2);
      chk("latency_cycles", 32'(vrise_cyc - cap1_cyc), 32'd2);
      chk("first_pixel", 32'(Pix_data), 32'h A1);
      capture_row(2, 16'hD4C3, 1);
      rmode = 0;
      wait_idle(50);
      check_log("nominal", 8'hA1, 8'hB2, 8'hC3, 8'hD4);

      // Backpressure
      acc_log.delete();
      rmode = 1;
      frame(16'hB2A1, 16'hD4C3, 2);
      wait_idle(50);
      check_log("backpressure", 8'hA1, 8'hB2, 8'hC3, 8'hD4);

      // Overrun
      acc_log.delete();
      rmode = 2;
      frame(16'hB2A1, 16'hD4C3, 1);
      frame(16'h2211, 16'h4433, 1);
      chk("ovr_sticky", 32'(Ovr), 32'd1);
      rmode = 0;
      wait_idle(50);
      check_log("overrun", 8'hA1, 8'hB2, 8'hC3, 8'hD4);

      // Reset mid-drain
      pulse_reset();
      acc_log.delete();
      rmode = 2;
      frame(16'hB2A1, 16'hD4C3, 1);
      rmode = 0;
      begin
         int n = 0;
         while (acc_log.size() < 2 && n < 40) begin
            tick(1);
            n++;
         end
      end
      chk("accepted_before_reset", 32'(acc_log.size()), 32'd2);
      Reset = 1'b1;
      #1;
      chk("reset_async", 32'({Pix_valid, Pix_data, Pix_last, Frame_done, Busy, Ovr, Seq_err}), 32'd0);
      tick(2);
      Reset = 1'b0;
      tick(1);
      acc_log.delete();
      frame(16'hB2A1, 16'hD4C3, 0);
      wait_idle(50);
      check_log("after_reset", 8'hA1, 8'hB2, 8'hC3, 8'hD4);

      // Both row selects on one capture
      pulse_reset();
      rmode = 2;
      capture_row(3, 16'h5566, 1);
      tick(2);
`ifdef PROTOCOL_CHECK_EN
      chk("both_sel_seq_err", 32'(Seq_err), 32'd1);
      chk("both_sel_no_valid", 32'(Pix_valid), 32'd0);
`else
      chk("both_sel_seq_err", 32'(Seq_err), 32'd0);
      chk("both_sel_valid", 32'(Pix_valid), 32'd1);
      chk("both_sel_data", 32'(Pix_data), 32'h66);
`endif
      pulse_reset();

      // Randomized frames, pacing and backpressure
      rmode = 3;
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 9) == 0)
            capture_row($urandom_range(0, 3), (C*DW)'($urandom), $urandom_range(1, 3));
         else
            frame((C*DW)'($urandom), (C*DW)'($urandom), $urandom_range(0, 4));
         tick($urandom_range(0, 6));
         if ($urandom_range(0, 4) == 0) rmode = $urandom_range(0, 3);
      end
      rmode = 0;
      wait_idle(400);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
      $fatal(1);
   end

endmodule

// File: doc/pixel_readout_capture.md
# pixel_readout_capture

Receive-side counterpart of the exposure/readout controller. Watches the controller's NRE_1/NRE_2 row-select and ADC conversion strobes, captures the column-parallel ADC result for each row at the end of each conversion, buffers one full 2-row frame and streams it out pixel by pixel over a valid/ready interface. Sits between the pixel array/ADC and the image output path, in the same Clk domain as the controller.

## Interface
- DATA_W, 8, bits per pixel sample
- COLS, 2, pixels per row (columns converted in parallel per ADC strobe)

- Clk  input  1  system clock, all logic on rising edge
- Reset  input  1  asynchronous, active-high reset
- NRE_1  input  1  row 1 select from controller, active-high
- NRE_2  input  1  row 2 select from controller, active-high
- ADC  input  1  conversion strobe from controller; Adc_data valid while high, held until ADC falls
- Adc_data  input  COLS*DATA_W  column ADC results, column c at bits [c*DATA_W +: DATA_W]
- Pix_ready  input  1  downstream ready
- Pix_valid  output  1  Pix_data holds a valid pixel
- Pix_data  output  DATA_W  pixel value
- Pix_last  output  1  qualifies final pixel of frame (row 2, column COLS-1)
- Frame_done  output  1  one-cycle pulse after last pixel accepted
- Busy  output  1  buffer non-empty or capture in progress
- Ovr  output  1  sticky overrun flag
- Seq_err  output  1  sticky protocol error flag (see Configuration)

## Operation
- Inputs are Clk-synchronous registered controller outputs: no synchronizer; one register stage (adc_q) for edge detect.
- Capture event: adc_q==1 && ADC==0. On that cycle's edge write all COLS columns of Adc_data into buffer row r, set row-full bit r. Row r = 1 if NRE_1 high, else 2 if NRE_2 high, else no capture.
- Buffer: 2 rows x COLS entries, one full bit per row.
- States: IDLE, CAPT (row 1 full, row 2 pending), DRAIN, with read pointer rd (0..2*COLS-1).
  - IDLE -> CAPT on row-1 capture; Busy=1.
  - Streaming starts as soon as row 1 full; no wait for row 2.
  - Row 2 pixels presented only after row-2 full bit set; Pix_valid drops between rows if row 2 not yet captured.
  - Row full bit cleared when its last column handshakes.
  - After rd==2*COLS-1 handshake: rd wraps to 0, Frame_done pulses, -> IDLE.
- Overrun: capture event into a row whose full bit is still set -> capture discarded, buffer unchanged, Ovr set (sticky until Reset).
- Pix_last = Pix_valid && rd==2*COLS-1.

## Timing
- Reset values: Pix_valid 0, Pix_data 0, Pix_last 0, Frame_done 0, Busy 0, Ovr 0, Seq_err 0; full bits 0, rd 0, adc_q 0, state IDLE.
- Capture latency: ADC low sampled at edge k -> buffer written at edge k -> Pix_valid high after edge k+1 (registered output).
- Handshake: transfer at rising edge with Pix_valid && Pix_ready; Pix_data/Pix_last stable while Pix_valid && !Pix_ready; Pix_valid never retracted before transfer.
- Throughput: one pixel per cycle with Pix_ready held high.
- Frame_done: high the cycle after final handshake, exactly one cycle.
- Simultaneous capture and drain of same row's last pixel at same edge: drain first, capture accepted (no Ovr).
- Reset mid-frame: immediate clear of all state and outputs; partial frame discarded.

## Configuration
- PROTOCOL_CHECK_EN defined: Seq_err set (sticky until Reset) on capture event with NRE_1 and NRE_2 both high, capture event with neither high, or row-2 capture while state IDLE (row 1 missing). Both-high case captures nothing; row-2-in-IDLE captures nothing.
- Not defined: Seq_err tied 0; both-high treated as row 1; neither-high ignored; row-2-in-IDLE ignored silently.

## Test plan
- Nominal frame (COLS=2, DATA_W=8): NRE_1, ADC pulse with Adc_data=16'hB2A1, ADC falls, NRE_2, ADC pulse with 16'hD4C3, Pix_ready=1 -> stream A1,B2,C3,D4, Pix_last on D4, Frame_done one cycle later, Busy 0.
- Backpressure: same frame, Pix_ready toggled 1/0 each cycle -> Pix_data held while stalled, order A1,B2,C3,D4, no loss.
- Overrun: Pix_ready=0, capture two full frames -> second row-1 capture discarded, Ovr=1; after draining, output is first frame only.
- Latency: ADC falls seen at edge k -> Pix_valid=1 after edge k+1, Pix_data=A1.
- Protocol check (macro on): ADC pulse with NRE_1=NRE_2=1 -> Seq_err=1, no Pix_valid; macro off -> captured as row 1, Seq_err=0.
- Reset mid-drain: assert Reset after B2 accepted -> all outputs 0 immediately; next nominal frame streams correctly from A-row.
